spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// Register-access bundle for spi_master: host request/response signals plus the four SPI pins.
// The master modport is the controller's view and the slave modport is the host/pad side.
interface spi_master_if #(
  parameter int ADDRSZ = 7
);
  logic              start;
  logic              rw;
  logic [ADDRSZ-1:0] addr;
  logic [7:0]        wdata;
  logic              busy;
  logic              done;
  logic [7:0]        rdata;
  logic              SCLK;
  logic              SSB;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, rw, addr, wdata, MISO,
    output busy, done, rdata, SCLK, SSB, MOSI
  );

  modport slave (
    output start, rw, addr, wdata, MISO,
    input  busy, done, rdata, SCLK, SSB, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI register-access master: one frame carries {rw, addr, data} MSB first.
// It captures MISO into rdata during the data byte of read frames.
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int ADDRSZ  = 7
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int FRAME_W = ADDRSZ + 9;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int CNT_W   = 9;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  // The idle cycle in which the next start is sampled is the last cycle of the SSB-high gap.
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(2 * CLK_DIV - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(ADDRSZ + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    GAP
  } state_t;

  state_t             state_reg,    state_next;
  logic [CNT_W-1:0]   half_cnt_reg, half_cnt_next;
  logic [BIT_W-1:0]   bit_cnt_reg,  bit_cnt_next;
  logic [FRAME_W-1:0] shift_reg,    shift_next;
  logic               read_reg,     read_next;
  logic               hold_reg,     hold_next;
  logic [7:0]         rdata_reg,    rdata_next;
  logic               sclk_reg,     sclk_next;
  logic               ssb_reg,      ssb_next;
  logic               mosi_reg,     mosi_next;
  logic               busy_reg,     busy_next;
  logic               done_reg,     done_next;
  logic               half_end;

  assign half_end = (half_cnt_reg == HALF_LAST);

  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    read_next     = read_reg;
    hold_next     = hold_reg;
    rdata_next    = rdata_reg;
    sclk_next     = sclk_reg;
    ssb_next      = ssb_reg;
    mosi_next     = mosi_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        half_cnt_next = '0;
        if (bus.start) begin
          shift_next   = {bus.rw, bus.addr, bus.rw ? 8'h00 : bus.wdata};
          read_next    = bus.rw;
          bit_cnt_next = '0;
          hold_next    = 1'b0;
          busy_next    = 1'b1;
          ssb_next     = 1'b0;
          sclk_next    = 1'b0;
          mosi_next    = bus.rw;
          state_next   = SETUP;
        end
      end

      SETUP: begin
        if (half_end) begin
          half_cnt_next = '0;
          sclk_next     = 1'b1;
          state_next    = SCLK_HI;
        end
      end

      SCLK_HI: begin
        if (half_end) begin
          if (read_reg && (bit_cnt_reg >= DATA_FIRST)) begin
            rdata_next = {rdata_reg[6:0], bus.MISO};
          end
          // Zeros shift in behind the frame, so MOSI is already 0 in the hold phase.
          shift_next    = {shift_reg[FRAME_W-2:0], 1'b0};
          mosi_next     = shift_reg[FRAME_W-2];
          sclk_next     = 1'b0;
          bit_cnt_next  = bit_cnt_reg + 1'b1;
          hold_next     = (bit_cnt_reg == BIT_LAST);
          half_cnt_next = '0;
          state_next    = SCLK_LO;
        end
      end

      SCLK_LO: begin
        if (half_end) begin
          half_cnt_next = '0;
          if (hold_reg) begin
            hold_next  = 1'b0;
            ssb_next   = 1'b1;
            mosi_next  = 1'b0;
            done_next  = 1'b1;
            state_next = GAP;
          end else begin
            sclk_next  = 1'b1;
            state_next = SCLK_HI;
          end
        end
      end

      GAP: begin
        if (half_cnt_reg == GAP_LAST) begin
          half_cnt_next = '0;
          busy_next     = 1'b0;
          state_next    = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      read_reg     <= 1'b0;
      hold_reg     <= 1'b0;
      rdata_reg    <= 8'h00;
      sclk_reg     <= 1'b0;
      ssb_reg      <= 1'b1;
      mosi_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      read_reg     <= read_next;
      hold_reg     <= hold_next;
      rdata_reg    <= rdata_next;
      sclk_reg     <= sclk_next;
      ssb_reg      <= ssb_next;
      mosi_reg     <= mosi_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign bus.SCLK  = sclk_reg;
  assign bus.SSB   = ssb_reg;
  assign bus.MOSI  = mosi_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.rdata = rdata_reg;

endmodule
